// File: rtl/packet_to_multichannel_mixer_if.sv
// Stream-side bundle for the multichannel mixer: AXI-Stream input beats
// and the mono valid/ready output. slave = mixer view, master = driver view.
interface packet_to_multichannel_mixer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  S_AXIS_TVALID;
  logic                  S_AXIS_TLAST;
  logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
  logic                  S_AXIS_TREADY;
  logic                  mono_sample_valid;
  logic                  mono_sample_ready;
  logic [DATA_WIDTH-1:0] mono_sample;

  modport slave (
    input  S_AXIS_TVALID,
    input  S_AXIS_TLAST,
    input  S_AXIS_TDATA,
    output S_AXIS_TREADY,
    output mono_sample_valid,
    input  mono_sample_ready,
    output mono_sample
  );

  modport master (
    output S_AXIS_TVALID,
    output S_AXIS_TLAST,
    output S_AXIS_TDATA,
    input  S_AXIS_TREADY,
    input  mono_sample_valid,
    output mono_sample_ready,
    input  mono_sample
  );
endinterface

// File: rtl/packet_to_multichannel_mixer.sv
// Mixes NUM_CHANNELS-sample PCM frames to one mono sample into a FWFT FIFO.
// Ports: clk/async-high reset, bus (stream in + mono out), mix_mode,
// err_clear, sticky frame_error, fifo_level.
module packet_to_multichannel_mixer #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          S_AXIS_ACLK,
  input  logic                          S_AXIS_ARESET,
  packet_to_multichannel_mixer_if.slave bus,
  input  logic [1:0]                    mix_mode,
  input  logic                          err_clear,
  output logic                          frame_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LOG_N = $clog2(NUM_CHANNELS);
  localparam int ACC_W = DATA_WIDTH + LOG_N;
  localparam int CNT_W = (LOG_N > 0) ? LOG_N : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [CNT_W-1:0] LAST_CH =
    CNT_W'(NUM_CHANNELS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'($signed({1'b0, {(DATA_WIDTH-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'($signed({1'b1, {(DATA_WIDTH-1){1'b0}}}));

  typedef enum logic {ACCUM, DISCARD} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_mode;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_pending;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr;
  logic [AW-1:0]           r_rd;
  logic [LVL_W-1:0]        r_level;

  logic                    w_tready;
  logic                    w_accept;
  logic                    w_first;
  logic                    w_lastpos;
  logic [1:0]              w_mode;
  logic signed [ACC_W-1:0] w_samp;
  logic signed [ACC_W-1:0] w_fold;
  logic [DATA_WIDTH-1:0]   w_mix;
  logic [LVL_W:0]          w_occ;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_valid;

  // A latched-but-unpushed result reserves a FIFO slot, so the
  // push one edge later can never hit a full FIFO.
  assign w_occ    = {1'b0, r_level} + {{LVL_W{1'b0}}, r_pending};
  assign w_tready = !S_AXIS_ARESET &&
                    (w_occ < (LVL_W+1)'(FIFO_DEPTH));
  assign w_accept = bus.S_AXIS_TVALID && w_tready;

  assign w_first   = (r_cnt == '0);
  assign w_lastpos = (r_cnt == LAST_CH);
  // Mode is taken live on channel 0, then frozen for the frame.
  assign w_mode    = w_first ? mix_mode : r_mode;
  assign w_samp    = ACC_W'($signed(bus.S_AXIS_TDATA));

  always_comb begin
    w_fold = w_samp;
    if (!w_first) begin
      case (w_mode)
        2'b00:   w_fold = r_acc + w_samp;
        2'b01:   w_fold = r_acc;
        2'b10:   w_fold = (w_samp > r_acc) ? w_samp : r_acc;
        default: w_fold = r_acc + w_samp;
      endcase
    end
  end

  always_comb begin
    w_mix = DATA_WIDTH'(w_fold);
    case (w_mode)
      2'b00: w_mix = DATA_WIDTH'(w_fold >>> LOG_N);
      2'b11: begin
        if (w_fold > SAT_MAX)
          w_mix = DATA_WIDTH'(SAT_MAX);
        else if (w_fold < SAT_MIN)
          w_mix = DATA_WIDTH'(SAT_MIN);
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      r_state   <= ACCUM;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_pending)
        r_pending <= 1'b0;
      if (err_clear)
        r_err <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          ACCUM: begin
            if (w_first)
              r_mode <= mix_mode;
            r_acc <= w_fold;
            if (bus.S_AXIS_TLAST && w_lastpos) begin
              r_result  <= w_mix;
              r_pending <= 1'b1;
              r_cnt     <= '0;
            end else if (bus.S_AXIS_TLAST) begin
              r_err <= 1'b1;
              r_cnt <= '0;
            end else if (w_lastpos) begin
              r_err   <= 1'b1;
              r_cnt   <= '0;
              r_state <= DISCARD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          DISCARD: begin
            if (bus.S_AXIS_TLAST)
              r_state <= ACCUM;
          end
        endcase
      end
    end
  end

  assign w_push  = r_pending;
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid && bus.mono_sample_ready;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (w_push)
      r_mem[r_wr] <= r_result;
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LVL_W'(1);
    end
  end

  assign bus.S_AXIS_TREADY     = w_tready;
  assign bus.mono_sample_valid = w_valid;
  // Memory is not reset, so the head is masked while empty.
  assign bus.mono_sample       = w_valid ? r_mem[r_rd] : '0;
  assign frame_error           = r_err;
  assign fifo_level            = r_level;
endmodule

// File: tb/tb_packet_to_multichannel_mixer.sv
// Bench for packet_to_multichannel_mixer: directed vector table,
// multi-cycle corner sequences and random frames against a frame model.
module tb_packet_to_multichannel_mixer;
  localparam int DW    = 32;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [1:0]    mix_mode;
  logic          err_clear;
  logic          frame_error;
  logic [LW-1:0] fifo_level;

  packet_to_multichannel_mixer_if #(.DATA_WIDTH(DW)) bus();

  packet_to_multichannel_mixer #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .bus(bus),
    .mix_mode(mix_mode),
    .err_clear(err_clear),
    .frame_error(frame_error),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: samples of one complete frame, mode of beat 0.
  function automatic logic [DW-1:0] mix_ref(input logic [1:0] mode,
                                            input longint s[$]);
    longint sum, mx, r, maxv, minv;
    maxv = (longint'(1) <<< (DW-1)) - 1;
    minv = -(longint'(1) <<< (DW-1));
    sum = 0;
    mx  = s[0];
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] > mx) mx = s[i];
    end
    case (mode)
      2'd0: begin
        r = sum / NCH;
        if ((sum % NCH) != 0 && sum < 0) r -= 1;
      end
      2'd1: r = s[0];
      2'd2: r = mx;
      default: r = (sum > maxv) ? maxv : ((sum < minv) ? minv : sum);
    endcase
    return r[DW-1:0];
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [DW-1:0] d, input logic last,
                      input logic [1:0] m);
    int t;
    t = 0;
    bus.S_AXIS_TDATA  = d;
    bus.S_AXIS_TLAST  = last;
    bus.S_AXIS_TVALID = 1'b1;
    mix_mode          = m;
    while (!bus.S_AXIS_TREADY && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.S_AXIS_TREADY) @(negedge clk);
    else check("tready_timeout", bus.S_AXIS_TREADY, 1);
    bus.S_AXIS_TVALID = 1'b0;
  endtask

  task automatic pop(input logic [DW-1:0] exp, input string name);
    int t;
    t = 0;
    while (!bus.mono_sample_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({name, "_valid"}, bus.mono_sample_valid, 1);
    check(name, bus.mono_sample, exp);
    bus.mono_sample_ready = 1'b1;
    @(negedge clk);
    bus.mono_sample_ready = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] bp_exp[5];
  logic [DW-1:0] exp_q[$];
  logic          model_err;
  logic          drv_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"avg_1_3",     2'd0, 2'd0, 32'h1, 32'h3, 32'h2});
    vecs.push_back('{"avg_m1_0",    2'd0, 2'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF});
    vecs.push_back('{"avg_min_min", 2'd0, 2'd0, 32'h80000000, 32'h80000000, 32'h80000000});
    vecs.push_back('{"avg_4_2",     2'd0, 2'd0, 32'h4, 32'h2, 32'h3});
    vecs.push_back('{"sat_pos",     2'd3, 2'd3, 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF});
    vecs.push_back('{"sat_neg",     2'd3, 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{"sat_5_m2",    2'd3, 2'd3, 32'h5, 32'hFFFFFFFE, 32'h3});
    vecs.push_back('{"max_m2_5",    2'd2, 2'd2, 32'hFFFFFFFE, 32'h5, 32'h5});
    vecs.push_back('{"max_min_max", 2'd2, 2'd2, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF});
    vecs.push_back('{"ch0_m2_5",    2'd1, 2'd1, 32'hFFFFFFFE, 32'h5, 32'hFFFFFFFE});
    vecs.push_back('{"switch_1to2", 2'd1, 2'd2, 32'hFFFFFFFE, 32'h5, 32'hFFFFFFFE});
    vecs.push_back('{"switch_2to1", 2'd2, 2'd1, 32'hFFFFFFFE, 32'h5, 32'h5});

    bus.S_AXIS_TVALID     = 1'b0;
    bus.S_AXIS_TLAST      = 1'b0;
    bus.S_AXIS_TDATA      = '0;
    bus.mono_sample_ready = 1'b0;
    mix_mode  = 2'd0;
    err_clear = 1'b0;
    rst       = 1'b0;
    #1 rst    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", bus.S_AXIS_TREADY, 0);
    check("rst_valid",  bus.mono_sample_valid, 0);
    check("rst_sample", bus.mono_sample, 0);
    check("rst_err",    frame_error, 0);
    check("rst_level",  fifo_level, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", bus.S_AXIS_TREADY, 1);

    // Directed vector table with latency checks.
    foreach (vecs[i]) begin
      send(vecs[i].d0, 1'b0, vecs[i].m0);
      send(vecs[i].d1, 1'b1, vecs[i].m1);
      check({vecs[i].name, "_lat1"}, bus.mono_sample_valid, 0);
      @(negedge clk);
      check({vecs[i].name, "_lat2"}, bus.mono_sample_valid, 1);
      check({vecs[i].name, "_lvl"}, fifo_level, 1);
      pop(vecs[i].exp, vecs[i].name);
      check({vecs[i].name, "_lvl0"}, fifo_level, 0);
    end

    // Backpressure: fill the FIFO with the consumer stalled.
    for (int i = 0; i < 5; i++)
      bp_exp[i] = 32'(i * 16 + 1) + 32'h2;
    for (int i = 0; i < 4; i++) begin
      send(32'(i * 16 + 1), 1'b0, 2'd3);
      send(32'h2, 1'b1, 2'd3);
    end
    check("bp_tready_pend", bus.S_AXIS_TREADY, 0);
    check("bp_level3", fifo_level, 3);
    @(negedge clk);
    check("bp_level4", fifo_level, 4);
    bus.S_AXIS_TDATA  = 32'(4 * 16 + 1);
    bus.S_AXIS_TLAST  = 1'b0;
    bus.S_AXIS_TVALID = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_stall_tready", bus.S_AXIS_TREADY, 0);
    check("bp_stall_level", fifo_level, 4);
    check("bp_head0", bus.mono_sample, bp_exp[0]);
    bus.mono_sample_ready = 1'b1;
    @(negedge clk);
    bus.mono_sample_ready = 1'b0;
    check("bp_resume_tready", bus.S_AXIS_TREADY, 1);
    @(negedge clk);
    bus.S_AXIS_TVALID = 1'b0;
    send(32'h2, 1'b1, 2'd3);
    check("bp_pend_level", fifo_level, 3);
    check("bp_head1", bus.mono_sample, bp_exp[1]);
    bus.mono_sample_ready = 1'b1;
    @(negedge clk);
    bus.mono_sample_ready = 1'b0;
    check("bp_pushpop_level", fifo_level, 3);
    for (int i = 2; i < 5; i++)
      pop(bp_exp[i], $sformatf("bp_out%0d", i));
    check("bp_drained", fifo_level, 0);

    // Framing errors.
    send(32'h1, 1'b1, 2'd0);
    check("short_err", frame_error, 1);
    @(negedge clk);
    check("short_no_out", fifo_level, 0);
    send(32'h5, 1'b0, 2'd0);
    send(32'h6, 1'b0, 2'd0);
    send(32'h7, 1'b1, 2'd0);
    check("long_err", frame_error, 1);
    @(negedge clk);
    check("long_no_out", fifo_level, 0);
    send(32'h1, 1'b0, 2'd0);
    send(32'h3, 1'b1, 2'd0);
    pop(32'h2, "after_err");
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("err_cleared", frame_error, 0);
    err_clear = 1'b1;
    send(32'h9, 1'b1, 2'd0);
    err_clear = 1'b0;
    check("err_set_wins", frame_error, 1);
    @(negedge clk);
    check("set_wins_no_out", fifo_level, 0);

    // Asynchronous reset with results queued and a partial frame.
    send(32'h1, 1'b0, 2'd0);
    send(32'h3, 1'b1, 2'd0);
    send(32'h5, 1'b0, 2'd0);
    send(32'h7, 1'b1, 2'd0);
    @(negedge clk);
    check("mr_level2", fifo_level, 2);
    send(32'h4, 1'b0, 2'd0);
    #2 rst = 1'b1;
    #1;
    check("mr_tready", bus.S_AXIS_TREADY, 0);
    check("mr_valid",  bus.mono_sample_valid, 0);
    check("mr_sample", bus.mono_sample, 0);
    check("mr_err",    frame_error, 0);
    check("mr_level",  fifo_level, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(32'h4, 1'b0, 2'd0);
    send(32'h2, 1'b1, 2'd0);
    @(negedge clk);
    check("mr_one_out", fifo_level, 1);
    pop(32'h3, "mr_result");
    check("mr_empty", bus.mono_sample_valid, 0);

    // Random frames against the frame-level model.
    model_err = 1'b0;
    drv_done  = 1'b0;
    fork
      begin
        for (int f = 0; f < 250; f++) begin
          int len;
          logic [1:0] m0;
          longint s[$];
          s = {};
          len = ($urandom_range(0, 99) < 80) ? NCH
                : int'($urandom_range(1, NCH + 2));
          m0 = 2'($urandom_range(0, 3));
          for (int b = 0; b < len; b++) begin
            logic [DW-1:0] d;
            int sel;
            sel = int'($urandom_range(0, 5));
            d = (sel == 0) ? 32'h7FFFFFFF
              : (sel == 1) ? 32'h80000000 : 32'($urandom);
            s.push_back(longint'($signed(d)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(d, b == len - 1,
                 (b == 0) ? m0 : 2'($urandom_range(0, 3)));
          end
          if (len == NCH) exp_q.push_back(mix_ref(m0, s));
          else model_err = 1'b1;
        end
        drv_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          bus.mono_sample_ready = ($urandom_range(0, 2) != 0);
          if (bus.mono_sample_valid && bus.mono_sample_ready) begin
            if (exp_q.size() == 0)
              check("rand_unexpected", bus.mono_sample_valid, 0);
            else
              check("rand_data", bus.mono_sample, exp_q.pop_front());
          end
        end
        @(negedge clk);
        bus.mono_sample_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("rand_drained", 64'(exp_q.size()), 0);
    check("rand_level", fifo_level, 0);
    check("rand_err", frame_error, model_err);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
